// File: rtl/cell_editor.sv
// rtl/cell_editor.sv - button debounce, edit cursor and single-cell write sequencer for the 4x4 life array
// Each button is synchronised and debounced; toggle presses become one IDLE->WRITE->SETTLE transaction.
module cell_editor #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_toggle,
  input  logic        lock,
  input  logic [15:0] alive,
  output logic [1:0]  row,
  output logic [1:0]  col,
  output logic        val,
  output logic        write_enb,
  output logic [15:0] cursor,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE} state_t;

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 toggle
  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       deb;
  logic [4:0]       deb_d;
  logic [4:0]       press;
  logic [CNT_W-1:0] cnt [5];

  logic [1:0] cur_row;
  logic [1:0] cur_col;
  logic [1:0] row_step;
  logic [1:0] col_step;
  state_t     state;
  state_t     state_next;
  logic       start;

  assign raw   = {btn_toggle, btn_right, btn_left, btn_down, btn_up};
  assign press = deb & ~deb_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // opposing presses in the same cycle cancel; 2'd3 is a modulo-4 decrement
  always_comb begin
    row_step = 2'd0;
    col_step = 2'd0;
    if (press[0] && !press[1]) row_step = 2'd3;
    if (press[1] && !press[0]) row_step = 2'd1;
    if (press[2] && !press[3]) col_step = 2'd3;
    if (press[3] && !press[2]) col_step = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_row <= 2'd0;
      cur_col <= 2'd0;
      cursor  <= 16'h0001;
    end else begin
      cur_row <= cur_row + row_step;
      cur_col <= cur_col + col_step;
      cursor  <= 16'd1 << {cur_row, cur_col};
    end
  end

  assign start = (state == IDLE) && press[4] && !lock;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    write_enb = (state == WRITE);
    busy      = (state == WRITE) || (state == SETTLE);
  end

  // address/data latch on the pre-move cursor and hold between transactions
  always_ff @(posedge clk) begin
    if (!reset) begin
      row <= 2'd0;
      col <= 2'd0;
      val <= 1'b0;
    end else if (start) begin
      row <= cur_row;
      col <= cur_col;
      val <= ~alive[{cur_row, cur_col}];
    end
  end

endmodule

// File: tb/tb_cell_editor.sv
// tb/tb_cell_editor.sv - directed bench for cell_editor with DEBOUNCE_CYCLES=4
module tb_cell_editor;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right, btn_toggle;
  logic        lock;
  logic [15:0] alive;
  logic [1:0]  row, col;
  logic        val, write_enb, busy;
  logic [15:0] cursor;

  int vectors = 0;
  int errors  = 0;
  int we_cnt  = 0;
  int busy_cnt = 0;
  logic [1:0] cap_row, cap_col;
  logic       cap_val;

  cell_editor #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_toggle(btn_toggle),
    .lock(lock), .alive(alive),
    .row(row), .col(col), .val(val), .write_enb(write_enb),
    .cursor(cursor), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enb) begin
      we_cnt  = we_cnt + 1;
      cap_row = row;
      cap_col = col;
      cap_val = val;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 toggle
  task automatic drive(input logic [4:0] m);
    btn_up     = m[0];
    btn_down   = m[1];
    btn_left   = m[2];
    btn_right  = m[3];
    btn_toggle = m[4];
  endtask

  task automatic press(input logic [4:0] m);
    drive(m);
    cycles(10);
    drive(5'b0);
    cycles(12);
  endtask

  task automatic clear_mon();
    we_cnt   = 0;
    busy_cnt = 0;
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    lock  = 1'b0;
    alive = 16'h0000;
    drive(5'b0);
    cycles(3);
    check("rst_cursor", 32'(cursor), 32'h0001);
    check("rst_we", 32'(write_enb), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rcv", {27'd0, row, col, val}, 0);
    reset = 1'b1;
    cycles(2);

    // glitch shorter than the debounce window
    drive(5'b01000);
    cycles(3);
    drive(5'b0);
    cycles(12);
    check("glitch_cursor", 32'(cursor), 32'h0001);
    press(5'b01000);
    check("held_cursor", 32'(cursor), 32'h0002);

    // wraparound
    press(5'b00100);
    check("back_origin", 32'(cursor), 32'h0001);
    press(5'b00001);
    check("wrap_up", 32'(cursor), 32'h1000);
    press(5'b00100);
    check("wrap_left", 32'(cursor), 32'h8000);
    press(5'b01000);
    check("wrap_right", 32'(cursor), 32'h1000);

    // walk to (1,2) and toggle
    press(5'b00010);
    press(5'b00010);
    press(5'b01000);
    press(5'b01000);
    check("at_1_2", 32'(cursor), 32'h0040);
    clear_mon();
    press(5'b10000);
    check("tog1_we_cnt", we_cnt, 1);
    check("tog1_busy_cnt", busy_cnt, 2);
    check("tog1_addr", {28'd0, cap_row, cap_col}, 32'h6);
    check("tog1_val", 32'(cap_val), 1);
    check("tog1_hold", {27'd0, row, col, val}, 32'hD);
    alive = 16'h0040;
    clear_mon();
    press(5'b10000);
    check("tog2_we_cnt", we_cnt, 1);
    check("tog2_addr", {28'd0, cap_row, cap_col}, 32'h6);
    check("tog2_val", 32'(cap_val), 0);

    // simultaneous moves at (2,0)
    press(5'b00010);
    press(5'b00100);
    press(5'b00100);
    check("at_2_0", 32'(cursor), 32'h0100);
    press(5'b01011);
    check("sim_move", 32'(cursor), 32'h0200);

    // toggle + right from (0,0)
    press(5'b00001);
    press(5'b00001);
    press(5'b00100);
    check("at_0_0", 32'(cursor), 32'h0001);
    alive = 16'h0000;
    clear_mon();
    press(5'b11000);
    check("togmove_we_cnt", we_cnt, 1);
    check("togmove_addr", {28'd0, cap_row, cap_col}, 0);
    check("togmove_val", 32'(cap_val), 1);
    check("togmove_cursor", 32'(cursor), 32'h0002);

    // lock blocks writes but not moves
    lock = 1'b1;
    clear_mon();
    press(5'b10000);
    check("lock_we_cnt", we_cnt, 0);
    check("lock_busy_cnt", busy_cnt, 0);
    press(5'b00010);
    check("lock_move", 32'(cursor), 32'h0020);
    lock = 1'b0;

    // reset during the WRITE cycle
    clear_mon();
    drive(5'b10000);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (write_enb) seen = 1'b1;
    end
    check("rstw_seen", 32'(seen), 1);
    reset = 1'b0;
    drive(5'b0);
    @(negedge clk);
    check("rstw_we", 32'(write_enb), 0);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_cursor", 32'(cursor), 32'h0001);
    cycles(2);
    reset = 1'b1;
    clear_mon();
    cycles(20);
    check("rstw_no_strobe", we_cnt, 0);
    check("rstw_no_busy", busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
